mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Multicycle FSM controller for the RV32I subset core: R-type ALU, OP-IMM, LW, SW and JAL.
- Sequences the shared-ALU datapath (PC, IR, A, B, ALUOut, MDR) through fetch, decode, execute, memory and writeback.
- Generates every datapath strobe and mux select, and exports its current state.
- Instantiated once in the core; drives the alu and register_file only through the datapath selects.

Parameters:
- None. State and ALU encodings are fixed constants in the shared package.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25].
- state  out  4  current FSM state.
- mem_read  out  1  memory read; address=ALUOut, MDR captures data_in.
- mem_write  out  1  memory write; address=ALUOut.
- reg_write  out  1  register file writes rd.
- ir_write  out  1  IR captures data_in.
- pc_write  out  1  PC captures ALU result.
- mem_to_reg  out  1  writeback source: 1=MDR, 0=ALUOut.
- alu_src_a  out  2  ALU A select: 00=PC, 10=A, others=0.
- alu_src_b  out  2  ALU B select: 00=B, 01=imm, 10=4, 11=0.
- imm_src  out  2  immediate select: 00=I, 01=S, 10=J.
- alu_control  out  4  ALU operation code.

Behaviour:
- Clock and reset: one clock (clk). resetn is asynchronous and active-low. While resetn=0, state=IF(0) immediately.
- Outputs are combinational from state plus opcode/funct3/funct7 (IR is stable after IF). Every strobe defaults to 0; selects and alu_control default to 0.
- Reset output values: state=0, ir_write=1, every other output 0.
- State encodings and transitions (one state per cycle):
  - IF(0): ir_write=1, address=PC. Next: ID.
  - ID(1): datapath latches A/B. For every opcode except JAL and unsupported ones: pc_write=1, src_a=00, src_b=10, ADD (PC+4). Next by opcode:
    - 0110011 → EX_R
    - 0010011 or 0000011 → EX_I
    - 0100011 → EX_S
    - 1101111 → EX_J
    - anything else, including 1110011 → HALT, with pc_write=0.
  - EX_R(2): src_a=10, src_b=00, alu_control from funct3/funct7. Next: WB_ALU.
  - EX_I(3): src_a=10, src_b=01, imm_src=00.
    - LOAD: ADD, next MEM_RD.
    - OP-IMM: alu_control from funct3; funct7[5] is honoured only for funct3=101 (SRAI). Next WB_ALU.
  - EX_S(4): src_a=10, src_b=01, imm_src=01, ADD. Next: MEM_WR.
  - EX_J(5): src_a=00, src_b=10, ADD (link value = PC+4). Next: WB_ALU.
  - MEM_RD(6): mem_read=1. Next: WB_MEM.
  - MEM_WR(7): mem_write=1. Next: IF.
  - WB_ALU(8): reg_write=1, mem_to_reg=0. If JAL, also pc_write=1, src_a=00, src_b=01, imm_src=10, ADD (target = PC+imm_j). Next: IF.
  - WB_MEM(9): reg_write=1, mem_to_reg=1. Next: IF.
  - HALT(10): all strobes 0. Held until resetn=0.
- Decoding rules:
  - R-type: funct3 000 selects SUB when funct7=0100000, otherwise ADD.
  - funct3 101 selects SRA when funct7[5]=1, otherwise SRL.
  - An unknown funct3/funct7 combination yields ADD.
- CPI per instruction:
  - R-type and OP-IMM: 4.
  - LW: 5.
  - SW: 4.
  - JAL: 4.
- Timing and exclusivity:
  - Memory is zero-wait: data_in is valid in the same cycle as mem_read.
  - mem_read and mem_write are never asserted together.
  - reg_write is asserted only in WB states.
- Reset in any state returns to IF asynchronously and drops all strobes except ir_write. An in-flight MEM_WR is aborted.

Decomposition:
- Package mc_pkg:
  - State constants 0–10.
  - Opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_JAL, OP_SYSTEM.
  - ALU codes: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLL=0101, SRL=0110, SRA=0111, SLT=1000, SLTU=1001. alu shares these codes.
  - Mux-select constants.
- One sub-module, mc_alu_decoder: (opcode, funct3, funct7) → alu_control for EX_R/EX_I.

Test Plan:
1. resetn=0 asserted asynchronously mid-EX_R → state=0 before the next clk edge, ir_write=1. Release → IF then ID on the following edges.
2. opcode 0110011, funct3 000:
   - funct7 0000000 → states 0,1,2,8,0; alu_control=0000 in EX_R; reg_write=1 only in state 8.
   - Repeat with funct7 0100000 → alu_control=0001.
3. opcode 0000011 → states 0,1,3,6,9,0. mem_read=1 only in state 6; reg_write=1 and mem_to_reg=1 in state 9; pc_write=1 in ID.
4. opcode 0100011 → states 0,1,4,7,0. imm_src=01 in state 4; mem_write=1 only in state 7; reg_write never 1.
5. opcode 1101111 → states 0,1,5,8,0. pc_write=0 in ID; src_b=10 in state 5. In state 8: pc_write=1, reg_write=1, imm_src=10, src_b=01.
6. OP-IMM, funct3 101:
   - funct7 0100000 → SRA(0111).
   - funct3 000, funct7 0100000 → ADD(0000).
   - opcode 1110011 → state 10, held 20 cycles with all strobes 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants for the multicycle RV32I control unit: FSM states,
// opcodes, ALU operation codes and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EX_R   = 4'd2,
        S_EX_I   = 4'd3,
        S_EX_S   = 4'd4,
        S_EX_J   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_ALU = 4'd8,
        S_WB_MEM = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    // Major opcodes (IR[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // funct7 value that turns ADD into SUB for R-type
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    // ALU operation codes, shared with the alu
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // ALU A operand select
    localparam logic [1:0] SRC_A_PC   = 2'b00;
    localparam logic [1:0] SRC_A_REG  = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;
    localparam logic [1:0] SRC_B_ZERO = 2'b11;

    // Immediate format select
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_J = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation decode for R-type and OP-IMM instructions.
// Anything that is not an ALU-class instruction decodes to ADD.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_control
);

    // Map funct3 (plus funct7 where it matters) onto an ALU code
    always_comb begin
        alu_control = ALU_ADD;
        if (opcode == OP_R || opcode == OP_IMM) begin
            case (funct3)
                // funct7 of OP-IMM is immediate bits, so SUB only exists for R-type
                3'b000: alu_control = (opcode == OP_R && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                3'b001: alu_control = ALU_SLL;
                3'b010: alu_control = ALU_SLT;
                3'b011: alu_control = ALU_SLTU;
                3'b100: alu_control = ALU_XOR;
                3'b101: alu_control = funct7[5] ? ALU_SRA : ALU_SRL;
                3'b110: alu_control = ALU_OR;
                3'b111: alu_control = ALU_AND;
                default: alu_control = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle FSM controller for the RV32I subset core (R, OP-IMM, LW, SW, JAL).
// All strobes and selects are decoded combinationally from the current
// state and the instruction fields held in IR.
module mc_control_unit
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] state,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [3:0] alu_control
);

    state_t     cur_state;
    state_t     next_state;
    logic [3:0] dec_alu;

    mc_alu_decoder u_alu_decoder (
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_control (dec_alu)
    );

    assign state = cur_state;

    // State register; reset forces IF immediately
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_state <= S_IF;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        next_state  = cur_state;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_REG;
        imm_src     = IMM_I;
        alu_control = ALU_ADD;

        case (cur_state)
            S_IF: begin
                ir_write   = 1'b1;
                next_state = S_ID;
            end
            S_ID: begin
                case (opcode)
                    OP_R:              next_state = S_EX_R;
                    OP_IMM, OP_LOAD:   next_state = S_EX_I;
                    OP_STORE:          next_state = S_EX_S;
                    OP_JAL:            next_state = S_EX_J;
                    default:           next_state = S_HALT;
                endcase
                // JAL keeps the old PC so EX_J can form the link value and
                // WB_ALU can form the jump target from the same PC.
                if (opcode == OP_R || opcode == OP_IMM ||
                    opcode == OP_LOAD || opcode == OP_STORE) begin
                    pc_write  = 1'b1;
                    alu_src_a = SRC_A_PC;
                    alu_src_b = SRC_B_FOUR;
                end
            end
            S_EX_R: begin
                alu_src_a   = SRC_A_REG;
                alu_src_b   = SRC_B_REG;
                alu_control = dec_alu;
                next_state  = S_WB_ALU;
            end
            S_EX_I: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_I;
                if (opcode == OP_LOAD) begin
                    next_state = S_MEM_RD;
                end else begin
                    alu_control = dec_alu;
                    next_state  = S_WB_ALU;
                end
            end
            S_EX_S: begin
                alu_src_a  = SRC_A_REG;
                alu_src_b  = SRC_B_IMM;
                imm_src    = IMM_S;
                next_state = S_MEM_WR;
            end
            S_EX_J: begin
                alu_src_a  = SRC_A_PC;
                alu_src_b  = SRC_B_FOUR;
                next_state = S_WB_ALU;
            end
            S_MEM_RD: begin
                mem_read   = 1'b1;
                next_state = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                next_state = S_IF;
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b0;
                if (opcode == OP_JAL) begin
                    pc_write  = 1'b1;
                    alu_src_a = SRC_A_PC;
                    alu_src_b = SRC_B_IMM;
                    imm_src   = IMM_J;
                end
                next_state = S_IF;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = S_IF;
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_IF;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: directed cases plus randomized
// instruction streams compared against a per-instruction cycle table model.
module tb_mc_control_unit;

    logic       clk;
    logic       resetn;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] state;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [3:0] alu_control;

    int n_tests = 0;
    int n_fail  = 0;

    mc_control_unit dut (
        .clk         (clk),
        .resetn      (resetn),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .state       (state),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one cycle
    typedef struct {
        int st;
        int mr, mw, rw, iw, pw, m2r;
        int sa, sb, is, alu;
    } rec_t;

    rec_t exp_q[$];

    task automatic check(input string tag, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
        end
    endtask

    function automatic rec_t mk(input int st);
        rec_t r;
        r.st = st; r.mr = 0; r.mw = 0; r.rw = 0; r.iw = 0; r.pw = 0; r.m2r = 0;
        r.sa = 0; r.sb = 0; r.is = 0; r.alu = 0;
        return r;
    endfunction

    // ALU code required for an ALU-class instruction
    function automatic int ref_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        int tbl[8] = '{0, 5, 8, 9, 4, 6, 3, 2}; // ADD SLL SLT SLTU XOR SRL OR AND
        int a;
        a = tbl[f3];
        if (f3 == 3'd5 && f7[5]) a = 7;
        if (f3 == 3'd0 && op == 7'b0110011 && f7 == 7'b0100000) a = 1;
        return a;
    endfunction

    // Build the per-cycle table for one instruction, starting at IF
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        rec_t r;
        bit supported;
        exp_q.delete();
        r = mk(0); r.iw = 1; exp_q.push_back(r);
        supported = (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 || op == 7'b0100011);
        r = mk(1);
        if (supported) begin r.pw = 1; r.sb = 2; end
        exp_q.push_back(r);
        case (op)
            7'b0110011: begin
                r = mk(2); r.sa = 2; r.alu = ref_alu(op, f3, f7); exp_q.push_back(r);
                r = mk(8); r.rw = 1; exp_q.push_back(r);
            end
            7'b0010011: begin
                r = mk(3); r.sa = 2; r.sb = 1; r.alu = ref_alu(op, f3, f7); exp_q.push_back(r);
                r = mk(8); r.rw = 1; exp_q.push_back(r);
            end
            7'b0000011: begin
                r = mk(3); r.sa = 2; r.sb = 1; exp_q.push_back(r);
                r = mk(6); r.mr = 1; exp_q.push_back(r);
                r = mk(9); r.rw = 1; r.m2r = 1; exp_q.push_back(r);
            end
            7'b0100011: begin
                r = mk(4); r.sa = 2; r.sb = 1; r.is = 1; exp_q.push_back(r);
                r = mk(7); r.mw = 1; exp_q.push_back(r);
            end
            7'b1101111: begin
                r = mk(5); r.sb = 2; exp_q.push_back(r);
                r = mk(8); r.rw = 1; r.pw = 1; r.sb = 1; r.is = 2; exp_q.push_back(r);
            end
            default: begin
                for (int i = 0; i < 20; i++) exp_q.push_back(mk(10));
            end
        endcase
    endtask

    task automatic check_rec(input rec_t r, input string pfx);
        check({pfx, ".state"},      int'(state),       r.st);
        check({pfx, ".mem_read"},   int'(mem_read),    r.mr);
        check({pfx, ".mem_write"},  int'(mem_write),   r.mw);
        check({pfx, ".reg_write"},  int'(reg_write),   r.rw);
        check({pfx, ".ir_write"},   int'(ir_write),    r.iw);
        check({pfx, ".pc_write"},   int'(pc_write),    r.pw);
        check({pfx, ".mem_to_reg"}, int'(mem_to_reg),  r.m2r);
        check({pfx, ".alu_src_a"},  int'(alu_src_a),   r.sa);
        check({pfx, ".alu_src_b"},  int'(alu_src_b),   r.sb);
        check({pfx, ".imm_src"},    int'(imm_src),     r.is);
        check({pfx, ".alu_ctl"},    int'(alu_control), r.alu);
    endtask

    // Called with the DUT in IF, shortly after a falling edge
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input string name);
        opcode = op; funct3 = f3; funct7 = f7;
        build(op, f3, f7);
        #1;
        for (int i = 0; i < exp_q.size(); i++) begin
            check_rec(exp_q[i], $sformatf("%s[%0d]", name, i));
            @(negedge clk); #1;
        end
    endtask

    // Asynchronous reset mid-cycle; leaves the DUT in IF with reset released
    task automatic apply_reset(input string name);
        rec_t r;
        #2 resetn = 1'b0;
        #1;
        r = mk(0); r.iw = 1;
        check_rec(r, {name, ".rst"});
        @(negedge clk);
        resetn = 1'b1;
        #1;
    endtask

    function automatic logic [6:0] rand_op();
        logic [6:0] o;
        case ($urandom_range(0, 9))
            0, 1, 9: o = 7'b0110011;
            2, 3:    o = 7'b0010011;
            4:       o = 7'b0000011;
            5:       o = 7'b0100011;
            6:       o = 7'b1101111;
            7:       o = 7'b1110011;
            default: begin
                o = 7'($urandom);
                if (o == 7'b0110011 || o == 7'b0010011 || o == 7'b0000011 ||
                    o == 7'b0100011 || o == 7'b1101111) o = 7'b1111111;
            end
        endcase
        return o;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] op, f7;
        logic [2:0] f3;
        resetn = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
        #1;
        apply_reset("init");

        // Directed sequences
        run_instr(7'b0110011, 3'b000, 7'b0000000, "add");
        run_instr(7'b0110011, 3'b000, 7'b0100000, "sub");
        run_instr(7'b0000011, 3'b010, 7'b0000000, "lw");
        run_instr(7'b0100011, 3'b010, 7'b0100000, "sw");
        run_instr(7'b1101111, 3'b111, 7'b1111111, "jal");
        run_instr(7'b0010011, 3'b101, 7'b0100000, "srai");
        run_instr(7'b0010011, 3'b000, 7'b0100000, "addi");
        run_instr(7'b0110011, 3'b101, 7'b0000000, "srl");

        // Asynchronous reset while in EX_R
        opcode = 7'b0110011; funct3 = 3'b111; funct7 = '0;
        @(negedge clk); @(negedge clk); #1;
        check("arst.pre_state", int'(state), 2);
        apply_reset("arst");
        check("arst.rel_state", int'(state), 0);
        @(negedge clk); #1;
        check("arst.id_state", int'(state), 1);
        apply_reset("arst2");

        // Unsupported opcode parks in HALT
        run_instr(7'b1110011, 3'b000, 7'b0000000, "ecall");
        check("halt.hold", int'(state), 10);
        apply_reset("halt");

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            op = rand_op();
            f3 = 3'($urandom);
            f7 = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000;
            if (op != 7'b0110011 && $urandom_range(0, 1) != 0) f7 = 7'($urandom);
            run_instr(op, f3, f7, $sformatf("rnd%0d", n));
            if (state != 4'd0) apply_reset($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
